// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity mode constants.
// Used by the transmitter and by the planned receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    UART_IDLE   = 3'd0,
    UART_START  = 3'd1,
    UART_DATA   = 3'd2,
    UART_PARITY = 3'd3,
    UART_STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Mode 2'b11 is reserved and behaves like PAR_NONE.
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time strobe generator: tick is high during the last clock of each bit time.
// The counter is forced to zero while clear is high so a new frame starts on a full bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_reg;

  assign tick = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: start, LSB-first data, optional parity,
// one or two stop bits. Word and frame options are latched at accept.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_SIZE    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [1:0]           par_mode,
  input  logic                 stop2,
  output logic                 tx_bit,
  output logic                 busy,
  output logic                 done
);

  localparam int IDX_W = $clog2(DATA_SIZE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_SIZE - 1);

  uart_state_e          state_reg, state_next;
  logic [DATA_SIZE-1:0] shift_reg, shift_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic                 par_en_reg, par_en_next;
  logic                 par_bit_reg, par_bit_next;
  logic                 stop2_reg, stop2_next;
  logic                 stop_cnt_reg, stop_cnt_next;
  logic                 tx_bit_reg, tx_bit_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 tick;

  // Holding the divider clear through IDLE also clears it on the accept edge.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(state_reg == UART_IDLE),
    .tick (tick)
  );

  assign tx_ready = (state_reg == UART_IDLE);
  assign tx_bit   = tx_bit_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= UART_IDLE;
      shift_reg    <= '0;
      idx_reg      <= '0;
      par_en_reg   <= 1'b0;
      par_bit_reg  <= 1'b0;
      stop2_reg    <= 1'b0;
      stop_cnt_reg <= 1'b0;
      tx_bit_reg   <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      idx_reg      <= idx_next;
      par_en_reg   <= par_en_next;
      par_bit_reg  <= par_bit_next;
      stop2_reg    <= stop2_next;
      stop_cnt_reg <= stop_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  // Outputs are computed one cycle ahead so the line changes exactly on the bit edge.
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    idx_next      = idx_reg;
    par_en_next   = par_en_reg;
    par_bit_next  = par_bit_reg;
    stop2_next    = stop2_reg;
    stop_cnt_next = stop_cnt_reg;
    tx_bit_next   = tx_bit_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;

    unique case (state_reg)
      UART_IDLE: begin
        tx_bit_next = 1'b1;
        busy_next   = 1'b0;
        if (tx_valid) begin
          shift_next    = tx_data;
          idx_next      = '0;
          par_en_next   = par_enabled(par_mode);
          par_bit_next  = (par_mode == PAR_ODD) ? ~^tx_data : ^tx_data;
          stop2_next    = stop2;
          stop_cnt_next = 1'b0;
          tx_bit_next   = 1'b0;
          busy_next     = 1'b1;
          state_next    = UART_START;
        end
      end
      UART_START: begin
        if (tick) begin
          tx_bit_next = shift_reg[0];
          state_next  = UART_DATA;
        end
      end
      UART_DATA: begin
        if (tick) begin
          if (idx_reg == IDX_LAST) begin
            if (par_en_reg) begin
              tx_bit_next = par_bit_reg;
              state_next  = UART_PARITY;
            end else begin
              tx_bit_next = 1'b1;
              state_next  = UART_STOP;
            end
          end else begin
            shift_next  = shift_reg >> 1;
            idx_next    = idx_reg + 1'b1;
            tx_bit_next = shift_reg[1];
          end
        end
      end
      UART_PARITY: begin
        if (tick) begin
          tx_bit_next = 1'b1;
          state_next  = UART_STOP;
        end
      end
      UART_STOP: begin
        if (tick) begin
          if (stop2_reg && !stop_cnt_reg) begin
            stop_cnt_next = 1'b1;
          end else begin
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = UART_IDLE;
          end
        end
      end
      default: begin
        tx_bit_next = 1'b1;
        busy_next   = 1'b0;
        state_next  = UART_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench: the driver queues reference frames at accept, monitors replay them
// against the serial line cycle by cycle. A second small instance covers DATA_SIZE=5.
module tb_uart_tx_cfg;

  localparam int DS   = 8;
  localparam int CPB  = 4;
  localparam int DS5  = 5;
  localparam int CPB5 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DS-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic [1:0]    par_mode = 2'b00;
  logic          stop2 = 1'b0;
  logic          tx_ready, tx_bit, busy, done;

  logic [DS5-1:0] d5_data = '0;
  logic           d5_valid = 1'b0;
  logic [1:0]     d5_par_mode = 2'b00;
  logic           d5_stop2 = 1'b0;
  logic           d5_ready, d5_bit, d5_busy, d5_done;

  uart_tx_cfg #(.DATA_SIZE(DS), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .par_mode(par_mode), .stop2(stop2), .tx_bit(tx_bit), .busy(busy), .done(done)
  );

  uart_tx_cfg #(.DATA_SIZE(DS5), .CLKS_PER_BIT(CPB5)) dut5 (
    .clk(clk), .rst(rst), .tx_data(d5_data), .tx_valid(d5_valid), .tx_ready(d5_ready),
    .par_mode(d5_par_mode), .stop2(d5_stop2), .tx_bit(d5_bit), .busy(d5_busy), .done(d5_done)
  );

  typedef struct {
    logic [15:0] bits;
    int          len;
    int          acc_cyc;
    bit          b2b;
  } frame_t;

  frame_t exp_q[$];
  frame_t exp5_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit rst_edge = 1'b0;
  int last_done = -100;
  int frames_done = 0;
  int n_sent = 0;
  bit d5_finished = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end

  // Reference frame: start 0, data LSB first, parity from the count of ones, stop bits 1.
  function automatic frame_t model(input logic [8:0] d, input int ds, input logic [1:0] pm,
                                   input logic s2, input int acc, input bit b2b);
    frame_t f;
    int ones = 0;
    int n = 0;
    f.bits = '0;
    f.bits[n] = 1'b0;
    n++;
    for (int i = 0; i < ds; i++) begin
      f.bits[n] = d[i];
      ones += int'(d[i]);
      n++;
    end
    if (pm == 2'b01) begin
      f.bits[n] = (ones % 2 == 1);
      n++;
    end else if (pm == 2'b10) begin
      f.bits[n] = (ones % 2 == 0);
      n++;
    end
    for (int i = 0; i < (s2 ? 2 : 1); i++) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.len     = n;
    f.acc_cyc = acc;
    f.b2b     = b2b;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                      input bit b2b, input int gap);
    int t = 0;
    forever begin
      @(negedge clk);
      if (tx_ready === 1'b1) break;
      tx_data  = DS'($urandom);
      par_mode = 2'($urandom);
      stop2    = 1'($urandom);
      tx_valid = b2b;
      t++;
      if (t > 500) begin
        check("ready_timeout", 32'(tx_ready), 32'd1);
        return;
      end
    end
    if (!b2b) begin
      tx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    tx_data  = d;
    par_mode = pm;
    stop2    = s2;
    tx_valid = 1'b1;
    exp_q.push_back(model({1'b0, d}, DS, pm, s2, cyc + 1, b2b));
    n_sent++;
    $display("send %0d: data=0x%02h par=%0d stop2=%0d b2b=%0d accept_cycle=%0d",
             n_sent, d, pm, s2, b2b, cyc + 1);
  endtask

  initial begin : monitor
    frame_t f;
    bit aborted;
    logic [3:0] seen, want;
    forever begin
      @(negedge clk);
      if (rst_edge) continue;
      if (done === 1'b1) check("spurious_done", 32'(done), 32'd0);
      if (tx_bit !== 1'b0) continue;
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'(tx_bit), 32'd1);
        for (int i = 0; i < 200 && busy === 1'b1; i++) @(negedge clk);
        continue;
      end
      f = exp_q.pop_front();
      check("accept_to_start", 32'(cyc), 32'(f.acc_cyc));
      if (f.b2b) check("b2b_gap", 32'(cyc - last_done), 32'd1);
      aborted = 1'b0;
      for (int k = 0; k < f.len; k++) begin
        want = {1'b0, 1'b0, 1'b1, f.bits[k]};
        seen = want;
        for (int c = 0; c < CPB; c++) begin
          if (k != 0 || c != 0) @(negedge clk);
          if (rst_edge) begin
            aborted = 1'b1;
            break;
          end
          if ({done, tx_ready, busy, tx_bit} !== want && seen === want)
            seen = {done, tx_ready, busy, tx_bit};
        end
        if (aborted) break;
        check($sformatf("frame_bit%0d_done_ready_busy_line", k), 32'(seen), 32'(want));
      end
      if (!aborted) begin
        @(negedge clk);
        aborted = rst_edge;
      end
      if (aborted) begin
        check("reset_abort_done_busy_ready_line", 32'({done, busy, tx_ready, tx_bit}), 32'b0011);
        $display("frame aborted by reset at cycle %0d", cyc);
        continue;
      end
      check("frame_end_done_busy_ready_line", 32'({done, busy, tx_ready, tx_bit}), 32'b1011);
      last_done = cyc;
      frames_done++;
      $display("frame %0d checked: %0d bits, done at cycle %0d", frames_done, f.len, cyc);
    end
  end

  initial begin : monitor5
    frame_t f;
    logic [3:0] seen, want;
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(rst === 1'b0 && d5_bit === 1'b0) && t < 500);
    if (exp5_q.size() == 0) begin
      check("d5_frame_present", 32'(exp5_q.size()), 32'd1);
    end else begin
      f = exp5_q.pop_front();
      check("d5_accept_to_start", 32'(cyc), 32'(f.acc_cyc));
      for (int k = 0; k < f.len; k++) begin
        want = {1'b0, 1'b0, 1'b1, f.bits[k]};
        seen = want;
        for (int c = 0; c < CPB5; c++) begin
          if (k != 0 || c != 0) @(negedge clk);
          if ({d5_done, d5_ready, d5_busy, d5_bit} !== want && seen === want)
            seen = {d5_done, d5_ready, d5_busy, d5_bit};
        end
        check($sformatf("d5_bit%0d_done_ready_busy_line", k), 32'(seen), 32'(want));
      end
      @(negedge clk);
      check("d5_end_done_busy_ready_line", 32'({d5_done, d5_busy, d5_ready, d5_bit}), 32'b1011);
      check("d5_done_latency", 32'(cyc - f.acc_cyc), 32'd16);
      $display("d5 frame checked: %0d bits, done at cycle %0d", f.len, cyc);
    end
    d5_finished = 1'b1;
  end

  initial begin : stim5
    do @(negedge clk); while (rst !== 1'b0);
    @(negedge clk);
    d5_data     = 5'h1B;
    d5_par_mode = 2'b01;
    d5_stop2    = 1'b0;
    d5_valid    = 1'b1;
    exp5_q.push_back(model({4'b0, 5'h1B}, DS5, 2'b01, 1'b0, cyc + 1, 1'b0));
    @(negedge clk);
    d5_valid    = 1'b0;
    d5_data     = 5'h04;
    d5_par_mode = 2'b10;
    d5_stop2    = 1'b1;
  end

  initial begin : main
    int acc;
    int t;
    repeat (3) @(negedge clk);
    check("reset_line_busy_done_ready", 32'({tx_bit, busy, done, tx_ready}), 32'b1001);
    check("d5_reset_line_busy_done_ready", 32'({d5_bit, d5_busy, d5_done, d5_ready}), 32'b1001);
    rst = 1'b0;

    send(8'hA5, 2'b01, 1'b0, 1'b0, 0);
    send(8'h00, 2'b10, 1'b0, 1'b0, 2);
    send(8'h01, 2'b10, 1'b0, 1'b0, 1);
    send(8'hFF, 2'b00, 1'b1, 1'b0, 0);
    send(8'h3C, 2'b00, 1'b0, 1'b0, 1);
    send(8'hC3, 2'b00, 1'b0, 1'b1, 0);
    send(8'h5A, 2'b01, 1'b0, 1'b0, 0);

    // Abort a frame with reset during data bit 3 (frame bit 4).
    send(8'h96, 2'b01, 1'b1, 1'b0, 0);
    acc = cyc + 1;
    @(negedge clk);
    tx_valid = 1'b0;
    while (cyc < acc + 4 * CPB + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    send(8'hA5, 2'b01, 1'b0, 1'b0, 0);
    for (int i = 0; i < 30; i++)
      send(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)));

    @(negedge clk);
    tx_valid = 1'b0;
    t = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0 || !d5_finished) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check("drain_pending_frames", 32'(exp_q.size()), 32'd0);
    check("frames_completed", 32'(frames_done), 32'(n_sent - 1));
    check("d5_finished", 32'(d5_finished), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised, runtime-configurable UART transmitter with a valid/ready input handshake and an internal baud divider. It serialises one word per frame as start bit, LSB-first data, optional parity bit and one or two stop bits. Each bit is held for exactly `CLKS_PER_BIT` clocks. It sits between a byte-producing client (register bank or FIFO) and the serial pin, and is the successor to the fixed one-bit-per-clock transmitter.

## Interface
- `DATA_SIZE`, default 8: data bits per frame; legal range 5..9.
- `CLKS_PER_BIT`, default 16: clocks per serial bit; must be ≥ 2.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tx_data` in DATA_SIZE: word to send; sampled only at accept.
- `tx_valid` in 1: client has a word.
- `tx_ready` out 1: block can accept; high only in IDLE.
- `par_mode` in 2: 00 none, 01 even, 10 odd, 11 treated as none; sampled at accept.
- `stop2` in 1: 0 gives one stop bit, 1 gives two; sampled at accept.
- `tx_bit` out 1: serial line, registered, idles high.
- `busy` out 1: high from accept until the frame ends.
- `done` out 1: one-cycle pulse when the last stop bit completes.

## Operation
- Accept happens on any edge where `tx_valid && tx_ready`. At accept the block latches `tx_data`, `par_mode` and `stop2`, clears the baud counter and the bit index, and enters START.
- States:
  - IDLE → START on accept.
  - START → DATA after 1 bit time.
  - DATA holds for DATA_SIZE bit times with index 0..DATA_SIZE-1, LSB first. It then goes to PARITY if the latched mode is even or odd, otherwise to STOP.
  - PARITY → STOP after 1 bit time.
  - STOP lasts 1 or 2 bit times, then returns to IDLE.
- Line level per state: IDLE 1, START 0, DATA the latched bit, STOP 1.
- Parity value:
  - Even: `^data`, so the total count of ones including the parity bit is even.
  - Odd: `~^data`.
  - Computed from the latched word, never from live `tx_data`.
- Bit time: the baud counter runs 0..CLKS_PER_BIT-1. A bit advance happens on the edge where the count equals CLKS_PER_BIT-1, and the counter then wraps to 0. Counter width is `$clog2(CLKS_PER_BIT)`.
- Inputs are ignored while not in IDLE. Changes to `tx_data`, `par_mode` or `stop2` mid-frame do not affect the frame in flight.
- Frame length in bits = 1 + DATA_SIZE + (parity ? 1 : 0) + (stop2 ? 2 : 1).

## Timing
- Reset values, effective on the edge where `rst` is high: `tx_bit`=1, `busy`=0, `done`=0, state IDLE, counters 0. `tx_ready` is 1 in the first cycle after reset is released.
- Reset mid-frame aborts the frame: `tx_bit` returns to 1 on that edge, and no `done` pulse is produced.
- Accept at edge N:
  - `tx_bit`=0 and `busy`=1 are visible from edge N.
  - Data bit 0 starts at edge N+CLKS_PER_BIT.
  - Bit k of the frame occupies the cycles from N+k·CLKS_PER_BIT up to N+(k+1)·CLKS_PER_BIT.
- End of frame, with L = frame length in bits: at edge N+L·CLKS_PER_BIT the state is IDLE, `busy`=0, `tx_ready`=1, `done`=1 for that one cycle, and `tx_bit`=1.
- Back-to-back: if `tx_valid` is held high, the next accept occurs in the IDLE cycle where `done`=1. The result is exactly one extra high cycle between frames, which extends the stop period and is legal.
- `tx_ready` is combinational from state (state==IDLE) and has no dependence on `tx_valid`.

## Structure
- Package `uart_pkg` holds:
  - state encoding: `UART_IDLE`, `UART_START`, `UART_DATA`, `UART_PARITY`, `UART_STOP`, each 3 bits;
  - parity mode constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`.
  - The future receiver shares this package.
- Sub-module `uart_baud_gen`, parametrised by `CLKS_PER_BIT`, with `clk`, `rst`, `clear` inputs and a `tick` output. It provides the bit-advance strobe and is reused by the receiver.
- The top holds the FSM, shift/index register, latched config, parity register and stop counter.

## Test plan
- CLKS_PER_BIT=4, DATA_SIZE=8, tx_data=0xA5, even parity, one stop:
  - line sequence 0,1,0,1,0,0,1,0,1, parity 0, stop 1, each bit 4 cycles;
  - `done` pulses 44 cycles after accept.
- Odd parity, 0x00 → parity bit 1; odd parity, 0x01 → parity bit 0; no parity, stop2=1, 0xFF → 11 bits, 44 cycles, two high stop bits.
- `tx_valid` held high with 0x3C then 0xC3, none/one stop → two frames separated by exactly one extra high cycle; `tx_ready` low throughout each frame.
- Change `tx_data`, `par_mode` and `stop2` during frame of 0x5A → transmitted bits, parity and frame length match the values latched at accept.
- Assert `rst` during data bit 3 → next cycle `tx_bit`=1, `busy`=0, no `done`; a subsequent accept sends a full correct frame.
- DATA_SIZE=5, CLKS_PER_BIT=2, 0x1B, even parity → bits 1,1,0,1,1, parity 0, 8-bit frame, `done` 16 cycles after accept.
